// File: rtl/alu_req_sequencer_if.sv
// Handshake bundle for the ALU request sequencer: command in, ALU request/response, packed results out.
// master is the sequencer side, slave is the environment (command source, ALU responder, result consumer).
interface alu_req_sequencer_if #(
   parameter int NLANES = 6
);
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [NLANES*10-1:0]   cmd_data;
   logic                   req_valid;
   logic                   req_ready;
   logic [3:0]             req_a;
   logic [3:0]             req_b;
   logic [1:0]             req_op;
   logic [2:0]             req_lane;
   logic                   rsp_valid;
   logic [4:0]             rsp_data;
   logic                   res_valid;
   logic                   res_ready;
   logic [NLANES*5-1:0]    res_data;
   logic                   err_mismatch;

   modport master (
      input  cmd_valid, cmd_data, req_ready, rsp_valid, rsp_data, res_ready,
      output cmd_ready, req_valid, req_a, req_b, req_op, req_lane,
             res_valid, res_data, err_mismatch
   );

   modport slave (
      output cmd_valid, cmd_data, req_ready, rsp_valid, rsp_data, res_ready,
      input  cmd_ready, req_valid, req_a, req_b, req_op, req_lane,
             res_valid, res_data, err_mismatch
   );
endinterface

// File: rtl/alu_req_sequencer.sv
// Time-multiplexes a bundle of NLANES 4-bit ALU commands onto one shared ALU and packs the results.
// Optional result checker enabled by defining ALU_SEQ_CHECK_EN; otherwise err_mismatch is tied low.
module alu_req_sequencer #(
   parameter int NLANES = 6
) (
   input logic                 clk,
   input logic                 rst_n,
   alu_req_sequencer_if.master bus
);

   localparam int CW = NLANES * 10;
   localparam int RW = NLANES * 5;
   localparam logic [2:0] LAST_LANE = 3'(NLANES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [2:0]      lane_q, lane_d;
   logic [CW-1:0]   bundle_q, bundle_d;
   logic [3:0]      req_a_q, req_a_d;
   logic [3:0]      req_b_q, req_b_d;
   logic [1:0]      req_op_q, req_op_d;
   logic [RW-1:0]   res_data_q, res_data_d;
   logic            cmd_ready_q, cmd_ready_d;
   logic            req_valid_q, req_valid_d;
   logic            res_valid_q, res_valid_d;
   logic [2:0]      next_lane;

   assign next_lane = lane_q + 3'd1;

   // Outputs are computed one cycle ahead so every interface signal comes straight from a flop.
   always_comb begin
      state_d     = state_q;
      lane_d      = lane_q;
      bundle_d    = bundle_q;
      req_a_d     = req_a_q;
      req_b_d     = req_b_q;
      req_op_d    = req_op_q;
      res_data_d  = res_data_q;
      cmd_ready_d = cmd_ready_q;
      req_valid_d = req_valid_q;
      res_valid_d = res_valid_q;
      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               bundle_d                     = bus.cmd_data;
               lane_d                       = 3'd0;
               {req_a_d, req_b_d, req_op_d} = bus.cmd_data[9:0];
               req_valid_d                  = 1'b1;
               cmd_ready_d                  = 1'b0;
               state_d                      = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (bus.req_ready) begin
               req_valid_d = 1'b0;
               state_d     = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.rsp_valid) begin
               res_data_d[int'(lane_q)*5 +: 5] = bus.rsp_data;
               if (lane_q == LAST_LANE) begin
                  res_valid_d = 1'b1;
                  state_d     = S_DONE;
               end else begin
                  lane_d                       = next_lane;
                  {req_a_d, req_b_d, req_op_d} = bundle_q[int'(next_lane)*10 +: 10];
                  req_valid_d                  = 1'b1;
                  state_d                      = S_ISSUE;
               end
            end
         end
         S_DONE: begin
            if (bus.res_ready) begin
               res_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         lane_q      <= 3'd0;
         bundle_q    <= '0;
         req_a_q     <= 4'd0;
         req_b_q     <= 4'd0;
         req_op_q    <= 2'd0;
         res_data_q  <= '0;
         cmd_ready_q <= 1'b1;
         req_valid_q <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         lane_q      <= lane_d;
         bundle_q    <= bundle_d;
         req_a_q     <= req_a_d;
         req_b_q     <= req_b_d;
         req_op_q    <= req_op_d;
         res_data_q  <= res_data_d;
         cmd_ready_q <= cmd_ready_d;
         req_valid_q <= req_valid_d;
         res_valid_q <= res_valid_d;
      end
   end

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.req_valid = req_valid_q;
   assign bus.req_a     = req_a_q;
   assign bus.req_b     = req_b_q;
   assign bus.req_op    = req_op_q;
   assign bus.req_lane  = lane_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;

`ifdef ALU_SEQ_CHECK_EN
   logic [4:0] exp_q, exp_d;
   logic       err_q, err_d;

   // Expected value is latched at request acceptance and compared only against a counted response.
   always_comb begin
      exp_d = exp_q;
      err_d = err_q;
      if (state_q == S_ISSUE && bus.req_ready) begin
         case (req_op_q)
            2'd0:    exp_d = {1'b0, req_a_q} + {1'b0, req_b_q};
            2'd1:    exp_d = {1'b0, req_a_q} - {1'b0, req_b_q};
            2'd2:    exp_d = {1'b0, req_a_q & req_b_q};
            default: exp_d = {1'b0, req_a_q | req_b_q};
         endcase
      end
      if (state_q == S_WAIT && bus.rsp_valid && bus.rsp_data != exp_q) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q <= 5'd0;
         err_q <= 1'b0;
      end else begin
         exp_q <= exp_d;
         err_q <= err_d;
      end
   end

   assign bus.err_mismatch = err_q;
`else
   assign bus.err_mismatch = 1'b0;
`endif

endmodule
